// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO plus launch sequencer in front of a UART transmitter.
//            The host can burst up to DEPTH bytes. The sequencer hands them one
//            at a time to the TX path through the tx_data / tx_data_valid /
//            tx_busy / tx_done handshake.
// Ports    : clk_i            - system clock, rising edge
//            rst_ni           - asynchronous active-low reset
//            wr_data_i        - host byte to enqueue
//            wr_en_i          - enqueue strobe
//            full_o / empty_o - registered occupancy flags
//            count_o          - bytes stored, 0..DEPTH
//            overflow_o       - 1-cycle pulse, a write was dropped while full
//            tx_data_o        - last launched byte, held until the next launch
//            tx_data_valid_o  - 1-cycle launch pulse to the transmitter
//            tx_busy_i        - transmitter is shifting a frame
//            tx_done_i        - transmitter end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_en_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_data_valid_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i
);

  localparam logic [ADDR_W:0]   c_full_count = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, empty_q, overflow_q;
  logic [7:0]          tx_data_q;
  logic                tx_data_valid_q;
  logic                do_push, do_pop;

  // full is the registered flag, so a pop in the same cycle never makes room.
  // A pop only happens on a launch out of IDLE, which also keeps a single
  // byte outstanding at the transmitter.
  always_comb begin
    do_push  = wr_en_i && !full_q;
    do_pop   = (state_q == ST_IDLE) && !empty_q && !tx_busy_i;
    wr_ptr_d = do_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      overflow_q      <= 1'b0;
      tx_data_q       <= 8'h00;
      tx_data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      full_q          <= (count_d == c_full_count);
      empty_q         <= (count_d == '0);
      overflow_q      <= wr_en_i && full_q;
      tx_data_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (do_pop) begin
            tx_data_q       <= mem_q[rd_ptr_q];
            tx_data_valid_q <= 1'b1;
            state_q         <= ST_WAIT_BUSY;
          end
        end
        // A very short frame may finish before busy is ever seen high.
        ST_WAIT_BUSY: begin
          if (tx_done_i) begin
            state_q <= ST_IDLE;
          end else if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full_o          = full_q;
  assign empty_o         = empty_q;
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;
  assign tx_data_o       = tx_data_q;
  assign tx_data_valid_o = tx_data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Accepted bytes go into a
//            scoreboard queue and are compared in order at each launch pulse.
//            A simple transmitter model answers each launch with busy for a
//            programmable number of cycles, followed by a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk, rst_n;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              full, empty, overflow, tx_data_valid;
  logic [ADDR_W:0]   count;
  logic [7:0]        tx_data;
  logic              tx_busy, tx_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_launch = 0;
  logic [7:0]  exp_q[$];
  bit          tx_auto     = 1'b0;
  int          busy_len    = 10;
  bit          outstanding = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .wr_data_i       (wr_data),
    .wr_en_i         (wr_en),
    .full_o          (full),
    .empty_o         (empty),
    .count_o         (count),
    .overflow_o      (overflow),
    .tx_data_o       (tx_data),
    .tx_data_valid_o (tx_data_valid),
    .tx_busy_i       (tx_busy),
    .tx_done_i       (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Launch monitor: every launch must match the oldest accepted byte.
  always @(negedge clk) begin
    if (tx_data_valid) begin
      n_launch++;
      check_eq("launch_while_outstanding", {31'd0, outstanding}, 32'd0);
      outstanding = 1'b1;
      check_eq("launch_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) check_eq("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Transmitter model: busy for busy_len cycles after a launch, then done.
  always begin
    @(negedge clk);
    if (tx_auto && tx_data_valid) begin
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done     = 1'b0;
      outstanding = 1'b0;
    end
  end

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_empty"},    {31'd0, empty},         32'd1);
    check_eq({pfx, "_full"},     {31'd0, full},          32'd0);
    check_eq({pfx, "_count"},    {27'd0, count},         32'd0);
    check_eq({pfx, "_overflow"}, {31'd0, overflow},      32'd0);
    check_eq({pfx, "_valid"},    {31'd0, tx_data_valid}, 32'd0);
    check_eq({pfx, "_tx_data"},  {24'd0, tx_data},       32'd0);
  endtask

  task automatic write_raw(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  // Flow-controlled write: holds off while full so every byte is accepted.
  task automatic write_flow(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (full && guard < 1000) begin
      wr_en = 1'b0;
      guard++;
      @(negedge clk);
    end
    if (guard >= 1000) check_eq("write_wait_timeout", {31'd0, full}, 32'd0);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
  endtask

  task automatic end_write();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drained();
    int guard = 0;
    while ((exp_q.size() != 0 || outstanding || !empty) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_timeout", {31'd0, (guard >= 3000)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;

    // 1: asynchronous reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check_reset("t1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2: single byte, launch two cycles after wr_en
    tx_auto = 1'b1; busy_len = 10;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check_eq("t2_empty_after_write", {31'd0, empty},         32'd0);
    check_eq("t2_count_one",         {27'd0, count},         32'd1);
    check_eq("t2_valid_not_early",   {31'd0, tx_data_valid}, 32'd0);
    @(negedge clk);
    check_eq("t2_valid",             {31'd0, tx_data_valid}, 32'd1);
    check_eq("t2_tx_data",           {24'd0, tx_data},       32'hA5);
    check_eq("t2_count_zero",        {27'd0, count},         32'd0);
    @(negedge clk);
    check_eq("t2_valid_one_cycle",   {31'd0, tx_data_valid}, 32'd0);
    wait_drained();
    check_eq("t2_tx_data_held",      {24'd0, tx_data},       32'hA5);

    // 3: burst of 17 with the transmitter held busy
    tx_auto = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) write_raw(8'(i), (i < 16));
    check_eq("t3_full",        {31'd0, full},     32'd1);
    check_eq("t3_count16",     {27'd0, count},    32'd16);
    check_eq("t3_no_ovf_yet",  {31'd0, overflow}, 32'd0);
    end_write();
    check_eq("t3_overflow",    {31'd0, overflow}, 32'd1);
    check_eq("t3_count_kept",  {27'd0, count},    32'd16);
    @(negedge clk);
    check_eq("t3_overflow_pulse", {31'd0, overflow}, 32'd0);
    tx_busy = 1'b0; tx_auto = 1'b1;
    wait_drained();

    // 4: 40-byte stream through pointer wrap
    l0 = n_launch;
    for (int i = 0; i < 40; i++) write_flow(8'(8'h30 + i));
    end_write();
    wait_drained();
    check_eq("t4_launch_count", n_launch - l0, 32'd40);

    // 5: write coinciding with a launch at count 3
    tx_auto = 1'b0; tx_busy = 1'b1;
    write_raw(8'hC1, 1'b1);
    write_raw(8'hC2, 1'b1);
    write_raw(8'hC3, 1'b1);
    end_write();
    check_eq("t5_count3",         {27'd0, count},         32'd3);
    check_eq("t5_no_launch_busy", {31'd0, tx_data_valid}, 32'd0);
    tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hE5; exp_q.push_back(8'hE5);
    @(negedge clk);
    wr_en = 1'b0;
    check_eq("t5_valid",          {31'd0, tx_data_valid}, 32'd1);
    check_eq("t5_count_stays3",   {27'd0, count},         32'd3);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0; tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0; outstanding = 1'b0; tx_auto = 1'b1;
    wait_drained();

    // 6: reset in WAIT_DONE with five bytes queued
    tx_auto = 1'b0; tx_busy = 1'b0;
    write_raw(8'h60, 1'b1);
    for (int i = 1; i < 6; i++) write_raw(8'(8'h60 + i), 1'b0);
    end_write();
    tx_busy = 1'b1;
    @(negedge clk);
    check_eq("t6_count5",          {27'd0, count},    32'd5);
    check_eq("t6_first_launched",  exp_q.size(),      32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset("t6");
    exp_q.delete();
    outstanding = 1'b0;
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0; rst_n = 1'b1;
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    write_raw(8'h77, 1'b1);
    end_write();
    check_eq("t6_count_one", {27'd0, count}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_no_launch_while_busy", {31'd0, tx_data_valid}, 32'd0);
      @(negedge clk);
    end
    tx_busy = 1'b0; tx_auto = 1'b1;
    wait_drained();
    check_eq("t6_tx_data", {24'd0, tx_data}, 32'h77);

    check_eq("total_launches",   n_launch,     32'd63);
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
